// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: reads opcode plus up to two operand bytes over a req/ready handshake,
// strobes IR_load, then waits for the execute stage. It owns the program counter.
module instruction_fetch_controller #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = 8'h00,
  parameter logic [7:0]        HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic [7:0]        opcode,
  output logic [7:0]        operando1,
  output logic [7:0]        operando2,
  output logic              IR_load,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH_OP = 3'd1;
  localparam logic [2:0] ST_FETCH_A  = 3'd2;
  localparam logic [2:0] ST_FETCH_B  = 3'd3;
  localparam logic [2:0] ST_LOAD     = 3'd4;
  localparam logic [2:0] ST_EXEC     = 3'd5;
  localparam logic [2:0] ST_HALT     = 3'd6;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        op1_q, op1_d;
  logic [7:0]        op2_q, op2_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH_OP;
      ST_FETCH_OP: begin
        if (mem_ready) begin
          opcode_d = mem_rdata;
          op1_d    = 8'h00;
          op2_d    = 8'h00;
          pc_d     = pc_q + PC_ONE;
          // Operand count is taken from the byte being captured, not the old opcode.
          state_d  = (mem_rdata[7:6] == 2'b00) ? ST_LOAD : ST_FETCH_A;
        end
      end
      ST_FETCH_A: begin
        if (mem_ready) begin
          op1_d   = mem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = (opcode_q[7:6] == 2'b01) ? ST_LOAD : ST_FETCH_B;
        end
      end
      ST_FETCH_B: begin
        if (mem_ready) begin
          op2_d   = mem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = (opcode_q == HALT_OPCODE) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
          state_d = ST_FETCH_OP;
          if (pc_load) begin
            pc_d = pc_in;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      opcode_q <= 8'h00;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  // All handshake/status outputs decode registered state, so they cannot glitch.
  assign mem_req   = (state_q == ST_FETCH_OP) || (state_q == ST_FETCH_A) ||
                     (state_q == ST_FETCH_B);
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign opcode    = opcode_q;
  assign operando1 = op1_q;
  assign operando2 = op2_q;
  assign IR_load   = (state_q == ST_LOAD);
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed programs followed by a random program,
// all checked cycle by cycle against an instruction-level model of memory and PC.
module tb_instruction_fetch_controller;

  logic       clk;
  logic       rst_n;
  logic       memReq;
  logic [7:0] memAddr;
  logic [7:0] memRdata;
  logic       memReady;
  logic [7:0] opcode;
  logic [7:0] operando1;
  logic [7:0] operando2;
  logic       irLoad;
  logic       execDone;
  logic       pcLoad;
  logic [7:0] pcIn;
  logic [7:0] pc;
  logic       halted;

  logic [7:0] progMem [256];
  logic [7:0] modelPc;
  int checks;
  int failures;

  assign memRdata = progMem[memAddr];

  instruction_fetch_controller #(
    .ADDR_W(8),
    .RESET_PC(8'hFE),
    .HALT_OPCODE(8'hFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_req(memReq),
    .mem_addr(memAddr),
    .mem_rdata(memRdata),
    .mem_ready(memReady),
    .opcode(opcode),
    .operando1(operando1),
    .operando2(operando2),
    .IR_load(irLoad),
    .exec_done(execDone),
    .pc_load(pcLoad),
    .pc_in(pcIn),
    .pc(pc),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic done, input logic ld,
                               input logic [7:0] tgt);
    memReady = rdy;
    execDone = done;
    pcLoad   = ld;
    pcIn     = tgt;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One instruction from FETCH_OP through EXEC (or into HALT). The expected bytes and PC
  // come from the program image and the operand-count rule alone.
  task automatic runInstr(input int stall, input int execWait, input logic doBranch,
                          input logic [7:0] target, input logic noise);
    logic [7:0] startPc, op, o1, o2, nextPc, addr;
    int cnt, ns;
    startPc = modelPc;
    op  = progMem[startPc];
    cnt = (op[7:6] == 2'b00) ? 0 : (op[7:6] == 2'b01) ? 1 : 2;
    addr = startPc + 8'd1;
    o1 = (cnt >= 1) ? progMem[addr] : 8'h00;
    addr = startPc + 8'd2;
    o2 = (cnt == 2) ? progMem[addr] : 8'h00;
    nextPc = startPc + 8'(cnt + 1);

    for (int b = 0; b <= cnt; b++) begin
      addr = startPc + 8'(b);
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s <= ns; s++) begin
        checkOutput("fetchReq", 8'(memReq), 8'h01);
        checkOutput("fetchAddr", memAddr, addr);
        checkOutput("fetchPc", pc, addr);
        checkOutput("fetchNoLoad", 8'(irLoad), 8'h00);
        applyStimulus(s == ns, 1'b0, noise, 8'($urandom));
        tick();
      end
    end

    checkOutput("irLoad", 8'(irLoad), 8'h01);
    checkOutput("loadOpcode", opcode, op);
    checkOutput("loadOp1", operando1, o1);
    checkOutput("loadOp2", operando2, o2);
    checkOutput("loadPc", pc, nextPc);
    checkOutput("loadReq", 8'(memReq), 8'h00);
    applyStimulus(1'b0, 1'b0, noise, 8'($urandom));
    tick();
    modelPc = nextPc;

    if (op == 8'hFF) begin
      for (int h = 0; h < 5; h++) begin
        checkOutput("haltFlag", 8'(halted), 8'h01);
        checkOutput("haltReq", 8'(memReq), 8'h00);
        checkOutput("haltNoLoad", 8'(irLoad), 8'h00);
        checkOutput("haltPc", pc, nextPc);
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1, 8'($urandom));
        tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      return;
    end

    for (int w = 0; w <= execWait; w++) begin
      checkOutput("execReq", 8'(memReq), 8'h00);
      checkOutput("execNoLoad", 8'(irLoad), 8'h00);
      checkOutput("execPc", pc, nextPc);
      checkOutput("execOpcode", opcode, op);
      checkOutput("execHalted", 8'(halted), 8'h00);
      if (w == execWait) applyStimulus(1'b0, 1'b1, doBranch, target);
      else               applyStimulus(1'b0, 1'b0, noise, 8'($urandom));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    if (doBranch) modelPc = target;
    checkOutput("nextReq", 8'(memReq), 8'h01);
    checkOutput("nextAddr", memAddr, modelPc);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) progMem[i] = 8'h00;
    // Three-byte opcode straddling the address wrap at the reset PC.
    progMem[8'hFE] = 8'h81; progMem[8'hFF] = 8'h11; progMem[8'h00] = 8'h22;
    // Stalled three-byte fetch.
    progMem[8'h10] = 8'h80; progMem[8'h11] = 8'hAA; progMem[8'h12] = 8'hBB;
    // Two-byte, one-byte, then halt.
    progMem[8'h20] = 8'h41; progMem[8'h21] = 8'h12; progMem[8'h22] = 8'h34;
    progMem[8'h23] = 8'hFF;

    tick();
    tick();
    checkOutput("rstPc", pc, 8'hFE);
    checkOutput("rstOpcode", opcode, 8'h00);
    checkOutput("rstOp1", operando1, 8'h00);
    checkOutput("rstOp2", operando2, 8'h00);
    checkOutput("rstIrLoad", 8'(irLoad), 8'h00);
    checkOutput("rstHalted", 8'(halted), 8'h00);
    checkOutput("rstReq", 8'(memReq), 8'h00);
    rst_n = 1'b1;
    tick();
    modelPc = 8'hFE;

    runInstr(0, 1, 1'b1, 8'h10, 1'b0);
    runInstr(2, 10, 1'b1, 8'h20, 1'b1);
    runInstr(0, 0, 1'b0, 8'h00, 1'b0);
    runInstr(0, 2, 1'b0, 8'h00, 1'b0);
    runInstr(0, 0, 1'b0, 8'h00, 1'b0);

    // Reset out of HALT, then abort an instruction while its last operand is pending.
    rst_n = 1'b0;
    tick();
    checkOutput("haltRstFlag", 8'(halted), 8'h00);
    checkOutput("haltRstPc", pc, 8'hFE);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("abortAddr", memAddr, 8'h00);
    checkOutput("abortOpcodeBefore", opcode, 8'h81);
    rst_n = 1'b0;
    tick();
    checkOutput("abortReq", 8'(memReq), 8'h00);
    checkOutput("abortPc", pc, 8'hFE);
    checkOutput("abortOpcode", opcode, 8'h00);
    checkOutput("abortOp1", operando1, 8'h00);
    checkOutput("abortOp2", operando2, 8'h00);
    checkOutput("abortIrLoad", 8'(irLoad), 8'h00);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    modelPc = 8'hFE;
    runInstr(0, 0, 1'b1, 8'h40, 1'b0);

    // Random program without halts, random wait states, exec delays and branches.
    for (int i = 0; i < 256; i++) begin
      progMem[i] = 8'($urandom);
      if (progMem[i] == 8'hFF) progMem[i] = 8'h7F;
    end
    for (int n = 0; n < 40; n++) begin
      runInstr(-1, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
               8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
